// File: rtl/fredkin_cswap_pipe.sv
// fredkin_cswap_pipe: WIDTH-lane pipelined controlled-swap (Fredkin) array
// with valid/ready flow control and a saturating swap counter.
//
// Ports: clk, rst_n (async, active-low), in_valid/in_ready, c_in, i_1, i_2,
//   out_valid/out_ready, c_out, o_1 (c?i_2:i_1), o_2 (c?i_1:i_2),
//   swap_cnt (delivered words with c!=0, saturating).
// Optional: define FREDKIN_CONSERVE_CHECK_EN to add the sticky cons_err
//   output, which flags a popcount mismatch between input and output words.
module fredkin_cswap_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] o_1,
  output logic [WIDTH-1:0] o_2,
  output logic [CNT_W-1:0] swap_cnt
`ifdef FREDKIN_CONSERVE_CHECK_EN
  ,
  output logic             cons_err
`endif
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic [WIDTH-1:0]  c_q  [STAGES];
  logic [WIDTH-1:0]  o1_q [STAGES];
  logic [WIDTH-1:0]  o2_q [STAGES];

  logic deliver;

  // Ready ripples back from the consumer: a stage may load if it is
  // empty or its word leaves at this edge.
  always_comb begin : ready_chain
    logic r;
    r  = out_ready;
    ld = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      ld[k] = !v[k] || r;
      r     = ld[k];
    end
  end

  assign in_ready  = rst_n && ld[0];
  assign out_valid = v[STAGES-1];
  assign c_out     = c_q[STAGES-1];
  assign o_1       = o1_q[STAGES-1];
  assign o_2       = o2_q[STAGES-1];
  assign deliver   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        c_q[k]  <= '0;
        o1_q[k] <= '0;
        o2_q[k] <= '0;
      end
    end else begin
      if (ld[0]) begin
        v[0]    <= in_valid;
        c_q[0]  <= c_in;
        o1_q[0] <= (c_in & i_2) | (~c_in & i_1);
        o2_q[0] <= (c_in & i_1) | (~c_in & i_2);
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          v[k]    <= v[k-1];
          c_q[k]  <= c_q[k-1];
          o1_q[k] <= o1_q[k-1];
          o2_q[k] <= o2_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_cnt <= '0;
    end else if (deliver && (|c_out) && !(&swap_cnt)) begin
      swap_cnt <= swap_cnt + 1'b1;
    end
  end

`ifdef FREDKIN_CONSERVE_CHECK_EN
  localparam int PW = $clog2(2*WIDTH+1);

  function automatic logic [PW-1:0] pop(input logic [WIDTH-1:0] x);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) s = s + PW'(x[i]);
    return s;
  endfunction

  logic [PW-1:0] pc_q [STAGES];
  logic [PW-1:0] pc_out;

  // Compare against the driven outputs so any corruption on the way
  // out of the last stage is caught.
  assign pc_out = pop(o_1) + pop(o_2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) pc_q[k] <= '0;
      cons_err <= 1'b0;
    end else begin
      if (ld[0]) pc_q[0] <= pop(i_1) + pop(i_2);
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) pc_q[k] <= pc_q[k-1];
      end
      if (deliver && (pc_out != pc_q[STAGES-1])) cons_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fredkin_cswap_pipe.sv
// tb_fredkin_cswap_pipe: directed bench with a scoreboard queue for
// fredkin_cswap_pipe (WIDTH=8, STAGES=2) plus a CNT_W=4 twin instance.
module tb_fredkin_cswap_pipe;

  localparam int W = 8;
  localparam int S = 2;

  typedef struct packed {
    logic [W-1:0] c;
    logic [W-1:0] o1;
    logic [W-1:0] o2;
  } word_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready, in_ready2;
  logic [W-1:0] c_in, i_1, i_2;
  logic         out_valid, out_valid2;
  logic         out_ready;
  logic [W-1:0] c_out, o_1, o_2;
  logic [W-1:0] c_out2, o_12, o_22;
  logic [15:0]  swap_cnt;
  logic [3:0]   swap_cnt2;
`ifdef FREDKIN_CONSERVE_CHECK_EN
  logic         cons_err, cons_err2;
`endif

  always #5 clk = ~clk;

  fredkin_cswap_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .c_in(c_in), .i_1(i_1), .i_2(i_2),
    .out_valid(out_valid), .out_ready(out_ready),
    .c_out(c_out), .o_1(o_1), .o_2(o_2),
    .swap_cnt(swap_cnt)
`ifdef FREDKIN_CONSERVE_CHECK_EN
    , .cons_err(cons_err)
`endif
  );

  fredkin_cswap_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .c_in(c_in), .i_1(i_1), .i_2(i_2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .c_out(c_out2), .o_1(o_12), .o_2(o_22),
    .swap_cnt(swap_cnt2)
`ifdef FREDKIN_CONSERVE_CHECK_EN
    , .cons_err(cons_err2)
`endif
  );

  int    total = 0;
  int    bad   = 0;
  int    ndel  = 0;
  int    exp_cnt = 0;
  bit    chk_data = 1'b1;
  word_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic word_t model(input logic [W-1:0] c,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    word_t r;
    r.c = c;
    for (int i = 0; i < W; i++) begin
      r.o1[i] = c[i] ? b[i] : a[i];
      r.o2[i] = c[i] ? a[i] : b[i];
    end
    return r;
  endfunction

  // Inputs change 1ns after posedge, so the negedge sees what the next
  // edge will act on.
  always @(negedge clk) begin
    word_t e;
    if (rst_n && in_valid && in_ready) q.push_back(model(c_in, i_1, i_2));
    if (rst_n && out_valid && out_ready) begin
      ndel++;
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL sb_underflow observed=%0d expected=1", q.size());
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.c != 0) exp_cnt++;
        if (chk_data) begin
          chk("sb_c", 32'(c_out), 32'(e.c));
          chk("sb_o1", 32'(o_1), 32'(e.o1));
          chk("sb_o2", 32'(o_2), 32'(e.o2));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_valid = 1'b1;
    c_in = c;
    i_1  = a;
    i_2  = b;
  endtask

  word_t        wm;
  logic [W-1:0] wc [6];
  logic [W-1:0] wa [6];
  logic [W-1:0] wb [6];
  int           n0;

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(8'hFF, 8'h12, 8'h34);
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_c_out", 32'(c_out), 0);
    chk("rst_o_1", 32'(o_1), 0);
    chk("rst_o_2", 32'(o_2), 0);
    chk("rst_swap_cnt", 32'(swap_cnt), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);

    // single swap word
    tick();
    drive(8'hF0, 8'hAA, 8'h55);
    tick();
    in_valid = 1'b0;
    chk("lat_not_yet", 32'(out_valid), 0);
    tick();
    chk("lat_valid", 32'(out_valid), 1);
    chk("swap_o_1", 32'(o_1), 32'h5A);
    chk("swap_o_2", 32'(o_2), 32'hA5);
    chk("swap_c_out", 32'(c_out), 32'hF0);
    tick();
    chk("swap_cnt_1", 32'(swap_cnt), 1);
    chk("swap_drained", 32'(out_valid), 0);

    // back-pressure
    for (int i = 0; i < 6; i++) begin
      wc[i] = W'($urandom);
      wa[i] = W'($urandom);
      wb[i] = W'($urandom);
    end
    n0 = ndel;
    out_ready = 1'b0;
    drive(wc[0], wa[0], wb[0]);
    tick();
    drive(wc[1], wa[1], wb[1]);
    tick();
    drive(wc[2], wa[2], wb[2]);
    #1;
    chk("bp_full_ready", 32'(in_ready), 0);
    wm = model(wc[0], wa[0], wb[0]);
    repeat (3) tick();
    chk("bp_hold_valid", 32'(out_valid), 1);
    chk("bp_hold_o_1", 32'(o_1), 32'(wm.o1));
    chk("bp_hold_o_2", 32'(o_2), 32'(wm.o2));
    chk("bp_still_full", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk("bp_comb_ready", 32'(in_ready), 1);
    for (int i = 2; i < 6; i++) begin
      drive(wc[i], wa[i], wb[i]);
      tick();
      chk("bp_stream_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    tick();
    chk("bp_tail_valid", 32'(out_valid), 1);
    tick();
    chk("bp_empty", 32'(out_valid), 0);
    chk("bp_delivered", 32'(ndel - n0), 6);

    // mid-stream reset
    out_ready = 1'b0;
    drive(8'h0F, 8'h33, 8'hCC);
    tick();
    drive(8'h81, 8'h01, 8'h80);
    tick();
    in_valid = 1'b0;
    chk("mr_inflight", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_swap_cnt", 32'(swap_cnt), 0);
    chk("mr_in_ready", 32'(in_ready), 0);
    q.delete();
    exp_cnt = 0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_stale", 32'(out_valid), 0);
    end

    // saturation and zero-control passthrough
    for (int i = 0; i < 20; i++) begin
      drive(8'h01, W'($urandom), W'($urandom));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(8'h00, W'($urandom), W'($urandom));
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("sat_model_cnt", 32'(exp_cnt), 20);
    chk("sat_cnt16", 32'(swap_cnt), 20);
    chk("sat_cnt4", 32'(swap_cnt2), 15);

`ifdef FREDKIN_CONSERVE_CHECK_EN
    for (int i = 0; i < 30; i++) begin
      drive(W'($urandom), W'($urandom), W'($urandom));
      out_ready = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("cons_clean", 32'(cons_err), 0);
    out_ready = 1'b0;
    drive(8'h00, 8'h00, 8'h00);
    tick();
    in_valid = 1'b0;
    tick();
    chk_data = 1'b0;
    force dut.o_1 = 8'h01;
    out_ready = 1'b1;
    tick();
    release dut.o_1;
    chk("cons_set", 32'(cons_err), 1);
    chk_data = 1'b1;
    repeat (3) tick();
    chk("cons_sticky", 32'(cons_err), 1);
    rst_n = 1'b0;
    #1;
    chk("cons_rst", 32'(cons_err), 0);
    tick();
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fredkin_cswap_pipe.md
# fredkin_cswap_pipe

Parametrised, pipelined array of Fredkin (controlled-swap) gates: WIDTH independent bit-lanes, each swapping its `a`/`b` bits when its own control bit is 1 and passing the control through unchanged. It is the registered, multi-lane successor of the single-bit Fredkin-via-Toffoli gate. It sits between valid/ready producers and consumers in the reversible-logic datapath, and also provides a transaction counter and an optional charge-conservation checker.

## Interface
- `WIDTH`, 8: lanes; each of `c`, `a`, `b` is WIDTH bits wide; legal range 1..32.
- `STAGES`, 2: pipeline register stages; legal range 1..4.
- `CNT_W`, 16: width of `swap_cnt`.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept an input word this cycle.
- `c_in`  in  WIDTH  per-lane control; bit i=1 swaps lane i.
- `i_1`  in  WIDTH  operand A.
- `i_2`  in  WIDTH  operand B.
- `out_valid`  out  1  output word present.
- `out_ready`  in  1  consumer accepts the output word.
- `c_out`  out  WIDTH  control, passed through.
- `o_1`  out  WIDTH  per lane: `c ? i_2 : i_1`.
- `o_2`  out  WIDTH  per lane: `c ? i_1 : i_2`.
- `swap_cnt`  out  CNT_W  delivered words with `c != 0`, saturating.
- `cons_err`  out  1  sticky conservation error; present only with the macro.

## Operation
- Swap logic is evaluated combinationally on the inputs and captured in stage 0. Stages 1..STAGES-1 move the word forward unchanged. Outputs are driven directly from the last stage's registers.
- Each stage k holds `v[k]`, `c`, `o_1`, `o_2`, and, with the macro, `pc`.
- Stage k loads when `!v[k] || adv[k+1]`. `adv[STAGES]` = `out_ready`.
- `in_ready` = `!v[0] || adv[1]`; it is forced to 0 while `rst_n` = 0.
- An input is accepted when `in_valid && in_ready`. An output is delivered when `out_valid && out_ready`.
- Holding: a stalled stage keeps its word; a valid word is never dropped or duplicated. While `out_valid` = 1 and `out_ready` = 0, outputs stay stable.
- `swap_cnt` increments by 1 on each delivery with `c_out != 0`. It saturates at 2^CNT_W-1 and does not wrap.
- A word with `c_in` = 0 passes unchanged. Applying the block twice to a word returns the original word (self-inverse).
- Reset (asynchronous, any time, including mid-stream): every `v[k]` and all data registers clear to 0, so `out_valid`, `c_out`, `o_1`, `o_2` = 0. `swap_cnt` = 0, `cons_err` = 0. Words in flight are discarded.

## Timing
- Latency: a word accepted at rising edge t has `out_valid` = 1 from just after edge t+STAGES-1, i.e. STAGES cycles.
- Throughput is 1 word/cycle when `out_ready` is held at 1.
- Full pipe with `out_ready` = 1: `in_ready` = 1, and accept and deliver happen at the same edge.
- Full pipe with `out_ready` = 0: `in_ready` = 0 in the same cycle (combinational ready path).
- Empty pipe: `in_ready` = 1.
- `in_ready` depends combinationally on `out_ready`. `out_valid` and all data outputs are purely registered.
- After `rst_n` deasserts, the first accept can occur at the first rising edge.

## Configuration
- `FREDKIN_CONSERVE_CHECK_EN` defined:
  - Stage 0 stores `pc` = popcount(`i_1`)+popcount(`i_2`), width clog2(2*WIDTH+1), and carries it with the word.
  - On each delivery, if popcount(`o_1`)+popcount(`o_2`) != `pc`, `cons_err` is set.
  - `cons_err` stays set until reset.
- Undefined: no `pc` registers and no checker; the `cons_err` port does not exist.

## Test plan
- Reset values: hold `rst_n`=0 with `in_valid`=1 → `in_ready`=0, `out_valid`=0, all outputs 0. Release → `in_ready`=1.
- Swap lanes (WIDTH=8, STAGES=2): `c_in`=8'hF0, `i_1`=8'hAA, `i_2`=8'h55 → after 2 cycles `o_1`=8'h5A, `o_2`=8'hA5, `c_out`=8'hF0, `swap_cnt`=1.
- Back-pressure: stream 6 words with `out_ready`=0 → `in_ready` drops after 2 accepts. Raise `out_ready` → words arrive in order, none lost, 1 per cycle.
- Mid-stream reset: pulse `rst_n` low while 2 words are in flight → `out_valid`=0 immediately, `swap_cnt`=0, and no stale word appears after release.
- Saturation (CNT_W=4): deliver 20 words with `c_in`=1 → `swap_cnt`=15. Words with `c_in`=0 do not increment it.
- With `FREDKIN_CONSERVE_CHECK_EN`: random traffic → `cons_err`=0. Force a bit flip on stage-1 `o_1` → `cons_err`=1 at that delivery and it stays 1 until reset.
